// File: rtl/quad_pkg.sv
// ---------------------------------------------------------------------------
// quad_pkg -- shared definitions for the quadrature decoder slice.
//   DEB_CNT_W    : width of the per-phase stability counter (DEB_CYCLES <= 255)
//   quad_state_t : decoder FSM states (INIT plus one state per {A,B} pair)
//   pair_state   : maps a filtered {A,B} pair to its FSM state
//   is_fwd/is_rev: classify a single-bit step between two pair states
// ---------------------------------------------------------------------------
package quad_pkg;

    localparam int unsigned DEB_CNT_W = 8;

    typedef enum logic [2:0] {
        INIT,
        S00,
        S01,
        S11,
        S10
    } quad_state_t;

    function automatic quad_state_t pair_state(input logic [1:0] ab);
        case (ab)
            2'b00:   return S00;
            2'b01:   return S01;
            2'b11:   return S11;
            default: return S10;
        endcase
    endfunction

    // Forward order: 00 -> 01 -> 11 -> 10 -> 00
    function automatic logic is_fwd(input quad_state_t from, input quad_state_t to);
        return ((from == S00) && (to == S01)) ||
               ((from == S01) && (to == S11)) ||
               ((from == S11) && (to == S10)) ||
               ((from == S10) && (to == S00));
    endfunction

    // Reverse order: 00 -> 10 -> 11 -> 01 -> 00
    function automatic logic is_rev(input quad_state_t from, input quad_state_t to);
        return ((from == S00) && (to == S10)) ||
               ((from == S10) && (to == S11)) ||
               ((from == S11) && (to == S01)) ||
               ((from == S01) && (to == S00));
    endfunction

endpackage

// File: rtl/quad_debounce.sv
// ---------------------------------------------------------------------------
// quad_debounce -- two-flop synchronizer followed by a stability filter for
// one quadrature phase.
//   clk     : clock, rising edge
//   reset   : synchronous, active-high
//   raw     : asynchronous phase input
//   filt    : filtered phase; follows raw only after DEB_CYCLES stable clocks
//   settled : synchronizer primed since reset and filt agrees with it
// ---------------------------------------------------------------------------
module quad_debounce
    import quad_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filt,
    output logic settled
);

    localparam logic [DEB_CNT_W-1:0] LAST = DEB_CNT_W'(DEB_CYCLES - 1);

    logic                 sync1;
    logic                 sync2;
    logic [DEB_CNT_W-1:0] cnt;
    logic [1:0]           fill;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            filt  <= 1'b0;
            cnt   <= '0;
            fill  <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (fill != 2'd2) begin
                fill <= fill + 2'd1;
            end
            // Any sample matching filt restarts the stability count.
            if (sync2 == filt) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                filt <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // The reset-cleared synchronizer looks stable before it has sampled the
    // real input; fill keeps settled low until two samples have passed.
    assign settled = (fill == 2'd2) && (sync2 == filt);

endmodule

// File: rtl/quad_decoder.sv
// ---------------------------------------------------------------------------
// quad_decoder -- debounced quadrature decoder producing count pulses.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   a, b  : quadrature phases, asynchronous to clk
//   up    : one-clock pulse per forward step (00->01->11->10->00)
//   down  : one-clock pulse per reverse step (00->10->11->01->00)
//   err   : one-clock pulse when both phases change together
//           (port exists only when QUAD_ERR_EN is defined)
// Latency from a stable raw edge to up/down is 2 + DEB_CYCLES + 1 clocks.
// ---------------------------------------------------------------------------
module quad_decoder
    import quad_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic up,
    output logic down
`ifdef QUAD_ERR_EN
    ,
    output logic err
`endif
);

    logic        fa;
    logic        fb;
    logic        sa;
    logic        sb;
    quad_state_t state;
    quad_state_t state_next;
    quad_state_t pair_st;
    logic        up_next;
    logic        down_next;
`ifdef QUAD_ERR_EN
    logic        err_next;
`endif

    quad_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
        .clk     (clk),
        .reset   (reset),
        .raw     (a),
        .filt    (fa),
        .settled (sa)
    );

    quad_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
        .clk     (clk),
        .reset   (reset),
        .raw     (b),
        .filt    (fb),
        .settled (sb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            up    <= 1'b0;
            down  <= 1'b0;
`ifdef QUAD_ERR_EN
            err   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            up    <= up_next;
            down  <= down_next;
`ifdef QUAD_ERR_EN
            err   <= err_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        up_next    = 1'b0;
        down_next  = 1'b0;
`ifdef QUAD_ERR_EN
        err_next   = 1'b0;
`endif
        pair_st    = pair_state({fa, fb});

        case (state)
            // Wait until both filters reflect the real inputs, so a step
            // that was in flight at reset is absorbed rather than decoded.
            INIT: begin
                if (sa && sb) begin
                    state_next = pair_st;
                end
            end
            default: begin
                if (pair_st != state) begin
                    state_next = pair_st;
                    if (is_fwd(state, pair_st)) begin
                        up_next = 1'b1;
                    end else if (is_rev(state, pair_st)) begin
                        down_next = 1'b1;
                    end else begin
`ifdef QUAD_ERR_EN
                        err_next = 1'b1;
`endif
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_quad_decoder.sv
// ---------------------------------------------------------------------------
// tb_quad_decoder -- scoreboard bench for quad_decoder (DEB_CYCLES = 4).
// Stimulus pushes the expected pulse kind and cycle; a monitor pops and
// compares whenever the DUT emits up, down or err. A 3-bit counter is
// driven by up/down to check accumulated position.
// ---------------------------------------------------------------------------
module tb_quad_decoder;

    localparam int unsigned DEB = 4;
    localparam int          LAT = 3 + DEB;
    localparam int          K_UP   = 0;
    localparam int          K_DOWN = 1;
    localparam int          K_ERR  = 2;
`ifdef QUAD_ERR_EN
    localparam int          ERR_EXP = K_ERR;
`else
    localparam int          ERR_EXP = -1;
`endif

    logic clk = 1'b0;
    logic reset;
    logic a;
    logic b;
    logic up;
    logic down;
    logic err_s;
`ifdef QUAD_ERR_EN
    logic err;
    assign err_s = err;
`else
    assign err_s = 1'b0;
`endif

    always #5 clk = ~clk;

    quad_decoder #(.DEB_CYCLES(DEB)) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .up    (up),
`ifdef QUAD_ERR_EN
        .down  (down),
        .err   (err)
`else
        .down  (down)
`endif
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0] cnt3;
    always @(posedge clk) begin
        if (reset)     cnt3 <= 3'd0;
        else if (up)   cnt3 <= cnt3 + 3'd1;
        else if (down) cnt3 <= cnt3 - 3'd1;
    end

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t expq[$];
    int  n_pass  = 0;
    int  n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Returns just after a rising edge, with cyc already updated.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ab(input logic na, input logic nb, input int exp_kind);
        a = na;
        b = nb;
        if (exp_kind >= 0) expq.push_back('{kind: exp_kind, cyc: cyc + LAT});
    endtask

    ev_t mon_e;
    int  mon_kind;
    always @(negedge clk) begin
        if (up && down) begin
            check("up_down_exclusive", 1, 0);
        end else if (up || down || err_s) begin
            mon_kind = up ? K_UP : (down ? K_DOWN : K_ERR);
            if (expq.size() == 0) begin
                check("unexpected_pulse", mon_kind, -1);
            end else begin
                mon_e = expq.pop_front();
                check("pulse_kind", mon_kind, mon_e.kind);
                check("pulse_cycle", cyc, mon_e.cyc);
            end
        end
    end

    logic [1:0] fwd [8];

    initial begin
        fwd = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
        reset = 1'b1;
        a = 1'b0;
        b = 1'b0;
        tick(5);
        check("reset_up", int'(up), 0);
        check("reset_down", int'(down), 0);
        check("reset_err", int'(err_s), 0);
        reset = 1'b0;
        tick(12);
        check("cnt_after_init", int'(cnt3), 0);

        // Eight forward steps, counter wraps 7 -> 0
        for (int i = 0; i < 8; i++) begin
            set_ab(fwd[i][1], fwd[i][0], K_UP);
            tick(10);
            if (i == 6) check("cnt_at_7", int'(cnt3), 7);
        end
        check("cnt_wrap", int'(cnt3), 0);

        // Reverse steps from 00
        set_ab(1'b1, 1'b0, K_DOWN);
        tick(10);
        set_ab(1'b1, 1'b1, K_DOWN);
        tick(10);
        check("cnt_rev2", int'(cnt3), 6);
        set_ab(1'b0, 1'b1, K_DOWN);
        tick(10);
        set_ab(1'b0, 1'b0, K_DOWN);
        tick(10);
        check("cnt_rev4", int'(cnt3), 4);

        // Bounce of DEB-1 clocks is rejected
        set_ab(1'b1, 1'b0, -1);
        tick(DEB - 1);
        set_ab(1'b0, 1'b0, -1);
        tick(15);
        check("cnt_bounce", int'(cnt3), 4);

        // Pulse of exactly DEB clocks is accepted: down then up
        set_ab(1'b1, 1'b0, K_DOWN);
        tick(DEB);
        set_ab(1'b0, 1'b0, K_UP);
        tick(15);
        check("cnt_deb_exact", int'(cnt3), 4);

        // Both phases change together: illegal, no count
        set_ab(1'b1, 1'b1, ERR_EXP);
        tick(12);
        set_ab(1'b0, 1'b0, ERR_EXP);
        tick(12);
        check("cnt_illegal", int'(cnt3), 4);

        // Reset two clocks after a legal edge: step dropped, next step decoded
        set_ab(1'b0, 1'b1, -1);
        tick(2);
        reset = 1'b1;
        tick(3);
        check("midreset_up", int'(up), 0);
        reset = 1'b0;
        tick(20);
        check("cnt_after_reset", int'(cnt3), 0);
        set_ab(1'b1, 1'b1, K_UP);
        tick(12);
        check("cnt_after_step", int'(cnt3), 1);

        tick(20);
        check("all_pulses_seen", expq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
